// File: rtl/log2_pos.sv
// log2_pos: 3-stage pipelined log2 of an unsigned Q2.13 operand, producing a signed Q4.11 result.
// Optional macro LOG2_CORR_EN adds the quadratic mantissa correction (S2 multiplier, S3 gain K_CORR).

module log2_pos #(
  parameter int K_CORR = 2816
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        I_VALID,
  output logic        O_READY,
  input  logic [15:0] I_DATA,
  output logic        O_VALID,
  input  logic        I_READY,
  output logic [15:0] O_DATA,
  output logic        O_ERR
);

  if (K_CORR < 0 || K_CORR > 8191) begin : g_bad_kcorr
    $error("K_CORR must fit unsigned Q0.13");
  end

  logic              adv;
  logic [3:0]        p_d;
  logic [12:0]       f1_d, f1_q, f2_q;
  logic signed [4:0] e1_d, e1_q, e2_q;
  logic              err1_d, err1_q, err2_q, err3_q;
  logic              v1_q, v2_q, v3_q;
  logic [13:0]       m_d;
  logic [15:0]       data3_d, data3_q;

  // One advance for the whole pipe: a stalled output freezes every stage.
  assign adv     = ~v3_q | I_READY;
  assign O_READY = adv;
  assign O_VALID = v3_q;
  assign O_DATA  = data3_q;
  assign O_ERR   = err3_q;

  // S1: leading-one detect and normalisation of the mantissa to 13 fraction bits
  always_comb begin
    p_d = '0;
    for (int i = 0; i < 15; i++)
      if (I_DATA[i]) p_d = 4'(i);
    f1_d   = (p_d == 4'd14) ? I_DATA[13:1] : 13'(I_DATA << (4'd13 - p_d));
    e1_d   = $signed({1'b0, p_d}) - 5'sd13;
    err1_d = I_DATA[15] | ~|I_DATA[14:0];
  end

`ifdef LOG2_CORR_EN
  logic [12:0] c1_d, c1_q;

  // f*(1-f) peaks at 0.25, so c1 never exceeds 2048
  assign c1_d = 13'((27'(f1_q) * (27'd8192 - 27'(f1_q))) >> 13);

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST)    c1_q <= '0;
    else if (adv) c1_q <= c1_d;
  end

  always_comb m_d = 14'(f2_q) + 14'((27'(c1_q) * 27'(K_CORR)) >> 13);
`else
  always_comb m_d = 14'(f2_q);
`endif

  // S3: exponent lands in the top five bits, mantissa contributes its upper 12 bits
  always_comb begin
    data3_d = {e2_q, 11'b0} + 16'(m_d >> 2);
    if (err2_q) data3_d = 16'h8000;
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      err1_q  <= 1'b0;
      err2_q  <= 1'b0;
      err3_q  <= 1'b0;
      e1_q    <= '0;
      e2_q    <= '0;
      f1_q    <= '0;
      f2_q    <= '0;
      data3_q <= '0;
    end else if (adv) begin
      v1_q    <= I_VALID;
      err1_q  <= err1_d;
      e1_q    <= e1_d;
      f1_q    <= f1_d;
      v2_q    <= v1_q;
      err2_q  <= err1_q;
      e2_q    <= e1_q;
      f2_q    <= f1_q;
      v3_q    <= v2_q;
      err3_q  <= err2_q;
      data3_q <= data3_d;
    end
  end

endmodule

// File: tb/tb_log2_pos.sv
// Scoreboard bench for log2_pos: driver queues expected results, a monitor pops them on each output transfer.

module tb_log2_pos;

  localparam int K = 2816;

  logic        I_CLK = 1'b0;
  logic        I_RST, I_VALID, O_READY, O_VALID, I_READY, O_ERR;
  logic [15:0] I_DATA, O_DATA;

  typedef struct {
    logic [15:0] d;
    logic        e;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_on = 1'b1;
  int   rdy_mode = 0;
  logic rdy_force = 1'b1;

  log2_pos #(.K_CORR(K)) dut (
    .I_CLK  (I_CLK),
    .I_RST  (I_RST),
    .I_VALID(I_VALID),
    .O_READY(O_READY),
    .I_DATA (I_DATA),
    .O_VALID(O_VALID),
    .I_READY(I_READY),
    .O_DATA (O_DATA),
    .O_ERR  (O_ERR)
  );

  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: log2(x) ~ e + f (+ correction) from the leading-one position, plain integer arithmetic.
  function automatic logic [16:0] model(input logic [15:0] x);
    int v, p, f, c2, m, r;
`ifdef LOG2_CORR_EN
    int c1;
`endif
    v = int'(x);
    if (x[15] || v == 0) return {1'b1, 16'h8000};
    p = 0;
    while ((v >> (p + 1)) != 0) p++;
    f  = (p <= 13) ? ((v << (13 - p)) % 8192) : ((v >> 1) % 8192);
    c2 = 0;
`ifdef LOG2_CORR_EN
    c1 = (f * (8192 - f)) / 8192;
    c2 = (c1 * K) / 8192;
`endif
    m = f + c2;
    r = (p - 13) * 2048 + m / 4;
    return {1'b0, 16'(r)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge I_CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] ed, input logic ee);
    int   g;
    exp_t e;
    I_VALID = 1'b1;
    I_DATA  = x;
    g = 0;
    forever begin
      @(negedge I_CLK);
      if (O_READY === 1'b1) begin
        e.d = ed; e.e = ee; e.cyc = cyc; e.lat = lat_on;
        q.push_back(e);
        break;
      end
      g++;
      if (g > 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: waited %0d cycles, O_READY never rose", g);
        break;
      end
    end
    @(posedge I_CLK);
    #1;
    I_VALID = 1'b0;
  endtask

  task automatic send_m(input logic [15:0] x);
    logic [16:0] r;
    r = model(x);
    send(x, r[15:0], r[16]);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 200) begin
      @(posedge I_CLK);
      g++;
    end
    chk("drain_empty", q.size(), 0);
    step(1);
  endtask

  // Downstream ready: held high, random, or forced by the main sequence.
  initial forever begin
    @(posedge I_CLK);
    #2;
    case (rdy_mode)
      0:       I_READY = 1'b1;
      1:       I_READY = ($urandom_range(3) != 0);
      default: I_READY = rdy_force;
    endcase
  end

  // Monitor: scoreboard pop on transfer, stall-hold and ready-drop checks.
  initial begin
    bit          hv;
    logic [15:0] hd;
    logic        he;
    exp_t        e;
    hv = 1'b0;
    forever begin
      @(negedge I_CLK);
      if (I_RST) hv = 1'b0;
      else begin
        if (hv) begin
          chk("stall_hold_valid", O_VALID, 1);
          chk("stall_hold_data", O_DATA, hd);
          chk("stall_hold_err", O_ERR, he);
        end
        hv = 1'b0;
        if (O_VALID && !I_READY) begin
          chk("oready_drop", O_READY, 0);
          hv = 1'b1; hd = O_DATA; he = O_ERR;
        end
        if (O_VALID && I_READY) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got %0h expected no result", O_DATA);
          end else begin
            e = q.pop_front();
            chk("data", O_DATA, e.d);
            chk("err", O_ERR, e.e);
            if (e.lat) chk("latency", cyc, e.cyc + 3);
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] x;
    I_RST = 1'b1; I_VALID = 1'b0; I_DATA = '0;
    repeat (3) @(posedge I_CLK);
    @(negedge I_CLK);
    chk("rst_valid", O_VALID, 0);
    chk("rst_data", O_DATA, 0);
    chk("rst_err", O_ERR, 0);
    chk("rst_ready", O_READY, 1);
    @(posedge I_CLK);
    #1;
    I_RST = 1'b0;
    #1;
    chk("ready_after_rst", O_READY, 1);

    // Powers of two, correction point, error operands, top-of-range
    lat_on = 1'b1;
    send(16'h2000, 16'h0000, 1'b0);
    send(16'h4000, 16'h0800, 1'b0);
    send(16'h1000, 16'hF800, 1'b0);
    send(16'h0001, 16'h9800, 1'b0);
`ifdef LOG2_CORR_EN
    send(16'h3000, 16'h04B0, 1'b0);
`else
    send(16'h3000, 16'h0400, 1'b0);
`endif
    send(16'h0000, 16'h8000, 1'b1);
    send(16'h8123, 16'h8000, 1'b1);
    send(16'h2000, 16'h0000, 1'b0);
    send(16'h7FFF, 16'h0FFF, 1'b0);
    drain();

    // Backpressure: six operands, ready low for four cycles mid-stream
    lat_on = 1'b0; rdy_mode = 2; rdy_force = 1'b1;
    step(1);
    fork
      for (int i = 0; i < 6; i++) send_m(16'($urandom_range(1, 32767)));
      begin
        step(3);
        rdy_force = 1'b0;
        step(4);
        rdy_force = 1'b1;
      end
    join
    drain();
    rdy_mode = 0;
    step(1);

    // Reset with three operands in flight
    lat_on = 1'b1;
    for (int i = 0; i < 3; i++) send_m(16'($urandom_range(1, 32767)));
    I_RST = 1'b1;
    q.delete();
    #1;
    chk("midrst_valid", O_VALID, 0);
    chk("midrst_data", O_DATA, 0);
    chk("midrst_err", O_ERR, 0);
    chk("midrst_ready", O_READY, 1);
    step(2);
    I_RST = 1'b0;
    step(6);
    chk("no_stale_after_rst", O_VALID, 0);
    send(16'h4000, 16'h0800, 1'b0);
    drain();

    // Random sweep with random downstream stalls and input gaps
    rdy_mode = 1; lat_on = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(15))
        0:       x = 16'h0000;
        1:       x = 16'h7FFF;
        2:       x = 16'h0001 << $urandom_range(14);
        3:       x = 16'($urandom) | 16'h8000;
        default: x = 16'($urandom) & 16'h7FFF;
      endcase
      if (i == 0) x = 16'h7FFF;
      if ($urandom_range(7) == 0) step(1);
      send_m(x);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
